// File: rtl/alu.sv
// alu: 8-bit registered arithmetic/logic unit with carry, zero and result-toggle count.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   a, b     in   8-bit unsigned operands (b unused for SHL/SHR/NOT)
//   op       in   3-bit operation select
//   y        out  registered 8-bit result
//   carry    out  registered carry-out / borrow / shifted-out bit
//   zero     out  registered flag, 1 when y == 0
//   toggles  out  registered count of y bits that changed at the last update (0..8)
//
// Every cycle out of reset loads all outputs; latency is exactly one cycle.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       carry,
    output logic       zero,
    output logic [3:0] toggles
);

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpAnd = 3'd2,
        OpOr  = 3'd3,
        OpXor = 3'd4,
        OpShl = 3'd5,
        OpShr = 3'd6,
        OpNot = 3'd7
    } op_e;

    logic [7:0] y_d, y_q;
    logic       carry_d, carry_q;
    logic       zero_d, zero_q;
    logic [3:0] toggles_d, toggles_q;

    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] flip;

    // 9-bit add/subtract; bit 8 of the difference is the borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y_d     = 8'h00;
        carry_d = 1'b0;
        unique case (op_e'(op))
            OpAdd: {carry_d, y_d} = sum;
            OpSub: {carry_d, y_d} = diff;
            OpAnd: y_d = a & b;
            OpOr:  y_d = a | b;
            OpXor: y_d = a ^ b;
            OpShl: begin
                y_d     = {a[6:0], 1'b0};
                carry_d = a[7];
            end
            OpShr: begin
                y_d     = {1'b0, a[7:1]};
                carry_d = a[0];
            end
            OpNot: y_d = ~a;
            default: begin
                y_d     = 8'h00;
                carry_d = 1'b0;
            end
        endcase
    end

    assign zero_d = (y_d == 8'h00);

    // Toggle count compares against the currently registered result.
    assign flip = y_d ^ y_q;

    always_comb begin
        toggles_d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            toggles_d = toggles_d + {3'b000, flip[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= 8'h00;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            toggles_q <= 4'd0;
        end else begin
            y_q       <= y_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            toggles_q <= toggles_d;
        end
    end

    assign y       = y_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign toggles = toggles_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu. Stimulus pushes expected results into a queue at the
// falling edge; a monitor pops one entry 1 time unit after each rising edge and compares.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       carry;
    logic       zero;
    logic [3:0] toggles;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic [3:0] t;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    logic [7:0] m_y;  // model's view of the registered result

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .op      (op),
        .y       (y),
        .carry   (carry),
        .zero    (zero),
        .toggles (toggles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.name, ".y"}, y, e.y);
        chk({e.name, ".carry"}, {7'd0, carry}, {7'd0, e.c});
        chk({e.name, ".zero"}, {7'd0, zero}, {7'd0, e.z});
        chk({e.name, ".toggles"}, {4'd0, toggles}, {4'd0, e.t});
    endtask

    // Reference model written with integer arithmetic.
    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic [2:0] iop, input logic [7:0] prev);
        exp_t e;
        int   ua = int'(ia);
        int   ub = int'(ib);
        int   r  = 0;
        int   c  = 0;
        case (iop)
            3'd0: begin r = (ua + ub) % 256; c = (ua + ub > 255) ? 1 : 0; end
            3'd1: begin r = (ua - ub + 256) % 256; c = (ua < ub) ? 1 : 0; end
            3'd2: r = int'(ia & ib);
            3'd3: r = int'(ia | ib);
            3'd4: r = int'(ia ^ ib);
            3'd5: begin r = (ua * 2) % 256; c = (ua >= 128) ? 1 : 0; end
            3'd6: begin r = ua / 2; c = ua % 2; end
            default: r = 255 - ua;
        endcase
        e.y    = r[7:0];
        e.c    = (c != 0);
        e.z    = (r == 0);
        e.t    = 4'($countones(e.y ^ prev));
        e.name = "rand";
        return e;
    endfunction

    // Directed issue: hand-computed expectation; called at the falling edge.
    task automatic issue(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] iop, input logic [7:0] ey, input logic ec,
                         input logic ez, input logic [3:0] et);
        exp_t e;
        @(negedge clk);
        a  = ia;
        b  = ib;
        op = iop;
        e.y = ey; e.c = ec; e.z = ez; e.t = et; e.name = name;
        sb_q.push_back(e);
        m_y = ey;
    endtask

    task automatic check_reset(input string name);
        exp_t e;
        e.y = 8'h00; e.c = 1'b0; e.z = 1'b1; e.t = 4'd0; e.name = name;
        chk_all(e);
    endtask

    // Monitor: outputs change on every rising edge; compare one entry per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                chk_all(sb_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [7:0] ra, rb;
        rst_n = 1'b1;
        a = 8'h00; b = 8'h00; op = 3'd0;
        m_y = 8'h00;

        // Reset between edges must act without a clock.
        #2 rst_n = 1'b0;
        #1 check_reset("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h0F; b = 8'h01; op = 3'd0;
        e.y = 8'h10; e.c = 1'b0; e.z = 1'b0; e.t = 4'd1; e.name = "first_add";
        sb_q.push_back(e);
        m_y = 8'h10;

        issue("add_wrap",  8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 4'd1);
        issue("add_80_80", 8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, 4'd0);
        issue("sub_borrow", 8'h05, 8'h07, 3'd1, 8'hFE, 1'b1, 1'b0, 4'd7);
        issue("sub_nob",   8'h07, 8'h05, 3'd1, 8'h02, 1'b0, 1'b0, 4'd6);
        issue("clr0",      8'h00, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1, 4'd1);
        issue("and",       8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 4'd2);
        issue("or",        8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0, 1'b0, 4'd4);
        issue("xor",       8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 1'b0, 4'd2);
        issue("shl",       8'h81, 8'h3C, 3'd5, 8'h02, 1'b1, 1'b0, 4'd5);
        issue("shr",       8'h81, 8'h3C, 3'd6, 8'h40, 1'b1, 1'b0, 4'd2);
        issue("not",       8'h81, 8'h3C, 3'd7, 8'h7E, 1'b0, 1'b0, 4'd5);
        issue("clr1",      8'h00, 8'h00, 3'd2, 8'h00, 1'b0, 1'b1, 4'd6);
        issue("tog8",      8'h00, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 4'd8);
        issue("tog0",      8'h00, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 4'd0);

        // Random soak with op cycling; a reset lands mid-run with an operation in flight.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            a  = ra;
            b  = rb;
            op = 3'(i % 8);
            if (i == 250) begin
                #2 rst_n = 1'b0;
                #1 check_reset("rst_mid");
                @(negedge clk);
                check_reset("rst_hold");
                rst_n = 1'b1;
                m_y = 8'h00;
            end
            e = model(a, b, op, m_y);
            sb_q.push_back(e);
            m_y = e.y;
        end

        // Drain
        for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
